// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encodings, serial line levels and the parity helper
// shared by uart_core and its sub-modules.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;
  typedef logic [MAX_DATA_BITS-1:0] word_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_IDLE = 3'd5
  } rx_state_t;

  // Zero-extended words leave the XOR unchanged, so one helper serves every width.
  function automatic logic parity_bit(input word_t word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period timer; ticks at CLK_DIV-1, or at CLK_DIV/2-1
// while half is set, and restarts from 0 after every tick or clear.
module uart_bit_timer #(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] FULL_TC = W'(CLK_DIV - 1);
  localparam logic [W-1:0] HALF_TC = W'(CLK_DIV / 2 - 1);

  logic [W-1:0] cnt;

  assign tick = !clear && (cnt == (half ? HALF_TC : FULL_TC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with valid/ready transmit and mid-bit sampled
// receive. Define UART_CORE_PARITY_EN to add a parity bit to every frame.
//
// TX state  | meaning
// IDLE      | line high, tx_ready high, waiting for tx_valid
// START     | driving start bit
// DATA      | shifting out data bits LSB first
// PARITY    | driving parity bit (parity build only)
// STOP      | driving STOP_BITS stop bits
//
// RX state  | meaning
// IDLE      | waiting for a falling edge on the synchronised line
// START     | half-bit wait, then confirm start bit is still low
// DATA      | sampling data bits at mid-bit
// PARITY    | sampling parity bit (parity build only)
// STOP      | sampling first stop bit, delivering the word
// WAIT_IDLE | stop bit was low; waiting for the line to return high
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  if (CLK_DIV < 4 || DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_core: parameter out of range");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic [3:0]           tx_bits;
  logic                 tx_tick;
`ifdef UART_CORE_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_ready = (tx_state == TX_IDLE);

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_tx_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tx_state == TX_IDLE),
    .half  (1'b0),
    .tick  (tx_tick)
  );

  // tx is registered so the pin never glitches; reset forces it high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bits  <= '0;
      tx       <= IDLE_LEVEL;
`ifdef UART_CORE_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE:
          if (tx_valid) begin
            tx_shift <= tx_data;
`ifdef UART_CORE_PARITY_EN
            tx_par   <= parity_bit(word_t'(tx_data), 1'(PARITY_ODD));
`endif
            tx       <= START_LEVEL;
            tx_state <= TX_START;
          end
        TX_START:
          if (tx_tick) begin
            tx       <= tx_shift[0];
            tx_bits  <= '0;
            tx_state <= TX_DATA;
          end
        TX_DATA:
          if (tx_tick) begin
            if (tx_bits == LAST_DATA) begin
              tx_bits  <= '0;
`ifdef UART_CORE_PARITY_EN
              tx       <= tx_par;
              tx_state <= TX_PARITY;
`else
              tx       <= STOP_LEVEL;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx_shift <= tx_shift >> 1;
              tx       <= tx_shift[1];
              tx_bits  <= tx_bits + 4'd1;
            end
          end
`ifdef UART_CORE_PARITY_EN
        TX_PARITY:
          if (tx_tick) begin
            tx       <= STOP_LEVEL;
            tx_state <= TX_STOP;
          end
`endif
        TX_STOP:
          if (tx_tick) begin
            if (tx_bits == LAST_STOP)
              tx_state <= TX_IDLE;
            else
              tx_bits <= tx_bits + 4'd1;
          end
        default: begin
          tx       <= IDLE_LEVEL;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  rx_state_t            rx_state;
  logic [2:0]           rx_sync;
  logic                 rx_s;
  logic                 rx_fall;
  logic [DATA_BITS-1:0] rx_shift;
  logic [3:0]           rx_bits;
  logic                 rx_tick;
`ifdef UART_CORE_PARITY_EN
  logic                 rx_par;
`else
  assign rx_parity_err = 1'b0;
`endif

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_sync[2] && !rx_sync[1];

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_rx_timer (
    .clk   (clk),
    .rst   (rst),
    .clear ((rx_state == RX_IDLE) || (rx_state == RX_WAIT_IDLE)),
    .half  (rx_state == RX_START),
    .tick  (rx_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync       <= '1;
      rx_state      <= RX_IDLE;
      rx_shift      <= '0;
      rx_bits       <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_CORE_PARITY_EN
      rx_par        <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_sync  <= {rx_sync[1:0], rx};
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE:
          if (rx_fall) rx_state <= RX_START;
        RX_START:
          if (rx_tick) begin
            if (rx_s != START_LEVEL) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_bits  <= '0;
              rx_state <= RX_DATA;
            end
          end
        RX_DATA:
          if (rx_tick) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_bits == LAST_DATA)
`ifdef UART_CORE_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            else
              rx_bits <= rx_bits + 4'd1;
          end
`ifdef UART_CORE_PARITY_EN
        RX_PARITY:
          if (rx_tick) begin
            rx_par   <= rx_s;
            rx_state <= RX_STOP;
          end
`endif
        RX_STOP:
          if (rx_tick) begin
            rx_data       <= rx_shift;
            rx_valid      <= 1'b1;
            rx_frame_err  <= (rx_s != STOP_LEVEL);
`ifdef UART_CORE_PARITY_EN
            rx_parity_err <= (rx_par != parity_bit(word_t'(rx_shift), 1'(PARITY_ODD)));
`endif
            rx_state      <= (rx_s == STOP_LEVEL) ? RX_IDLE : RX_WAIT_IDLE;
          end
        RX_WAIT_IDLE:
          if (rx_s == IDLE_LEVEL) rx_state <= RX_IDLE;
        default:
          rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed bench for uart_core at CLK_DIV=16, 8 data bits,
// 1 stop bit, even parity when UART_CORE_PARITY_EN is defined.
module tb_uart_core;

  localparam int CLK_DIV = 16;
  localparam int DB      = 8;
`ifdef UART_CORE_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + DB + P + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;

  int         n_vec = 0;
  int         n_err = 0;
  int         rx_cnt = 0;
  int         base;
  logic [7:0] cap_data = 8'h00;
  logic       cap_fe = 1'b0;
  logic       cap_pe = 1'b0;

  uart_core #(
    .CLK_DIV    (CLK_DIV),
    .DATA_BITS  (DB),
    .STOP_BITS  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx            (tx),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt   = rx_cnt + 1;
      cap_data = rx_data;
      cap_fe   = rx_frame_err;
      cap_pe   = rx_parity_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic exp_level(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= DB) return d[i-1];
    if (P == 1 && i == DB + 1) return ^d;
    return 1'b1;
  endfunction

  // Called at the first START cycle; returns at the cycle after the last stop cycle.
  task automatic check_tx_frame(input logic [7:0] d);
    for (int i = 0; i < NBITS; i++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        chk($sformatf("tx_bit%0d_c%0d", i, c), {31'd0, tx}, {31'd0, exp_level(d, i)});
        if (c == 0 || c == CLK_DIV - 1)
          chk($sformatf("tx_ready_low_bit%0d", i), {31'd0, tx_ready}, 32'd0);
        step();
      end
    end
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop_lvl, input logic par_flip);
    rx = 1'b0;
    step(CLK_DIV);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      step(CLK_DIV);
    end
    if (P == 1) begin
      rx = (^d) ^ par_flip;
      step(CLK_DIV);
    end
    rx = stop_lvl;
    step(CLK_DIV);
  endtask

  initial begin
    step(3);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);
    chk("rst_parity_err", {31'd0, rx_parity_err}, 32'd0);
    rst = 1'b1;
    step(4);

    // single frame 0xA5
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    chk("a5_ready_before", {31'd0, tx_ready}, 32'd1);
    step();
    tx_valid = 1'b0;
    check_tx_frame(8'hA5);
    chk("a5_ready_after", {31'd0, tx_ready}, 32'd1);
    chk("a5_tx_idle", {31'd0, tx}, 32'd1);
    step(5);

    // back-to-back 0x00 then 0xFF
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    step();
    tx_data  = 8'hFF;
    check_tx_frame(8'h00);
    chk("b2b_ready_pulse", {31'd0, tx_ready}, 32'd1);
    chk("b2b_gap_tx", {31'd0, tx}, 32'd1);
    step();
    tx_valid = 1'b0;
    check_tx_frame(8'hFF);
    chk("b2b_ready_end", {31'd0, tx_ready}, 32'd1);
    step(5);

`ifdef UART_CORE_PARITY_EN
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check_tx_frame(8'h07);
    chk("par07_ready_end", {31'd0, tx_ready}, 32'd1);
    step(5);
`endif

    // rx good frame 0x3C
    base = rx_cnt;
    rx_send(8'h3C, 1'b1, 1'b0);
    rx = 1'b1;
    step(8);
    chk("rx3c_count", rx_cnt, base + 1);
    chk("rx3c_cap", {24'd0, cap_data}, 32'h3C);
    chk("rx3c_data_held", {24'd0, rx_data}, 32'h3C);
    chk("rx3c_fe", {31'd0, cap_fe}, 32'd0);
    chk("rx3c_pe", {31'd0, cap_pe}, 32'd0);

    // false start then 0x81
    base = rx_cnt;
    rx = 1'b0;
    step(6);
    rx = 1'b1;
    step(40);
    chk("false_start_count", rx_cnt, base);
    rx_send(8'h81, 1'b1, 1'b0);
    rx = 1'b1;
    step(8);
    chk("rx81_count", rx_cnt, base + 1);
    chk("rx81_cap", {24'd0, cap_data}, 32'h81);
    chk("rx81_fe", {31'd0, cap_fe}, 32'd0);

    // framing error with line held low
    base = rx_cnt;
    rx_send(8'h5A, 1'b0, 1'b0);
    step(40);
    chk("fe_count", rx_cnt, base + 1);
    chk("fe_cap_data", {24'd0, cap_data}, 32'h5A);
    chk("fe_flag", {31'd0, cap_fe}, 32'd1);
    chk("fe_flag_held", {31'd0, rx_frame_err}, 32'd1);
    step(100);
    chk("fe_no_second_while_low", rx_cnt, base + 1);
    rx = 1'b1;
    step(20);
    chk("fe_no_frame_on_rise", rx_cnt, base + 1);
    rx_send(8'hC3, 1'b1, 1'b0);
    rx = 1'b1;
    step(8);
    chk("rxc3_count", rx_cnt, base + 2);
    chk("rxc3_cap", {24'd0, cap_data}, 32'hC3);
    chk("rxc3_fe_cleared", {31'd0, cap_fe}, 32'd0);
    chk("rxc3_pe", {31'd0, cap_pe}, 32'd0);

`ifdef UART_CORE_PARITY_EN
    base = rx_cnt;
    rx_send(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    step(8);
    chk("rxpar_count", rx_cnt, base + 1);
    chk("rxpar_data", {24'd0, cap_data}, 32'h07);
    chk("rxpar_pe", {31'd0, cap_pe}, 32'd1);
    chk("rxpar_fe", {31'd0, cap_fe}, 32'd0);
    rx_send(8'h07, 1'b1, 1'b0);
    rx = 1'b1;
    step(8);
    chk("rxpar_good_pe", {31'd0, cap_pe}, 32'd0);
`endif

    // reset in the middle of a TX frame
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step(50);
    rst = 1'b0;
    #1;
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    chk("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
    step(2);
    rst = 1'b1;
    step(2);
    chk("post_rst_tx", {31'd0, tx}, 32'd1);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check_tx_frame(8'h3C);
    chk("post_rst_ready", {31'd0, tx_ready}, 32'd1);

    // reset in the middle of an RX frame
    base = rx_cnt;
    rx = 1'b0;
    step(CLK_DIV);
    rx = 1'b1;
    step(CLK_DIV);
    rx = 1'b0;
    step(CLK_DIV);
    rst = 1'b0;
    step(2);
    chk("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
    rx  = 1'b1;
    rst = 1'b1;
    step(200);
    chk("rst_mid_rx_no_pulse", rx_cnt, base);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART core with configurable data width, bit period and stop-bit count, plus valid/ready transmit handshake and mid-bit-sampled receive with error flags. It replaces the fixed 8-bit transmitter/receiver pairing in the protocols area. It sits between a byte-stream client (FIFO, bus bridge, test controller) and the board-level `tx`/`rx` pins.

## Interface
- `CLK_DIV`, default 868: clocks per bit period; must be at least 4.
- `DATA_BITS`, default 8: payload bits per frame, 5..9, sent and received LSB first.
- `STOP_BITS`, default 1: 1 or 2 stop bits, transmitted and checked.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; used only when parity is compiled in.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_data`  in  DATA_BITS  word to send; sampled on handshake.
- `tx_valid`  in  1  client has a word.
- `tx_ready`  out  1  core can accept a word.
- `tx`  out  1  serial output; idle high.
- `rx`  in  1  serial input; asynchronous to `clk`.
- `rx_data`  out  DATA_BITS  last received word; held until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse when a frame completes.
- `rx_frame_err`  out  1  stop bit sampled low; valid with `rx_valid`.
- `rx_parity_err`  out  1  parity mismatch; valid with `rx_valid`.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `rx_frame_err`=0, `rx_parity_err`=0. Both FSMs return to IDLE.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE to START on `tx_valid && tx_ready`. `tx_data` is latched into a shift register and `tx_ready` drops.
  - START drives 0 for CLK_DIV cycles.
  - DATA shifts out DATA_BITS bits, CLK_DIV cycles each.
  - PARITY drives 1 bit; this state is skipped when parity is compiled out.
  - STOP drives 1 for STOP_BITS×CLK_DIV cycles, then goes to IDLE.
- RX path:
  - `rx` passes through a 2-flop synchroniser.
  - RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE to START on a synchronised falling edge.
  - START re-samples after CLK_DIV/2 cycles. If the line is high, the start is false: go back to IDLE with no output.
  - Every later bit is sampled CLK_DIV cycles after the previous sample, i.e. at mid-bit.
  - Only the first stop bit is checked, even when STOP_BITS=2.
  - At the first stop-bit sample: load `rx_data`, pulse `rx_valid`, and set both error flags for that frame. A frame with an error is still delivered.
  - If the stop bit was 0 (framing error or break), the FSM goes to WAIT_IDLE and stays until the synchronised line is high, then returns to IDLE. Otherwise it goes straight to IDLE.
- The RX path has no backpressure. The client must consume `rx_data` before the next frame completes.
- The error flags hold their value until the next `rx_valid`.
- TX and RX are fully independent and may run simultaneously.

## Timing
- First transmitted bit: `tx` falls on the clock edge after the handshake cycle.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × CLK_DIV cycles, where P = 1 with parity compiled in and 0 without.
- `tx_ready` rises in the cycle after the last stop-bit cycle.
- Back-to-back frames: a word presented with `tx_valid` already high starts in that next cycle, with no idle gap beyond the stop bits.
- RX latency: `rx_valid` pulses 2 (synchroniser) + CLK_DIV/2 + (DATA_BITS + P + 1) × CLK_DIV cycles after the falling `rx` edge, ±1 cycle.
- Bit timers are counters of width $clog2(CLK_DIV). They reload to 0 on every state change; TX reaches terminal count at CLK_DIV−1.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously) and the partial frame is abandoned. A partially received frame is discarded and `rx_valid` does not pulse.

## Configuration
- Macro: `UART_CORE_PARITY_EN`.
- Defined:
  - A parity bit follows the data bits, even or odd according to PARITY_ODD.
  - TX computes parity over the latched word.
  - RX compares the received parity bit and sets `rx_parity_err` on mismatch.
- Undefined:
  - The PARITY states are removed and frames carry no parity bit.
  - `rx_parity_err` is tied to 0; the port stays so the interface is identical in both builds.

## Structure
- Package `uart_pkg` holds:
  - the TX and RX state enums;
  - the constants for idle line level (1), start level (0) and stop level (1);
  - a function returning parity of a word for a given parity mode.
- Sub-module `uart_bit_timer`:
  - parametrised by CLK_DIV;
  - inputs are `clk`, `rst`, `clear`, `half`;
  - output is a one-cycle `tick`, at CLK_DIV−1 or at CLK_DIV/2−1 when `half` is set;
  - one instance for TX, one for RX.

## Test plan
All scenarios use CLK_DIV=16, DATA_BITS=8, STOP_BITS=1.
- Send 0xA5 -> `tx` reads 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles. `tx_ready` stays low for 160 cycles and rises on cycle 161.
- Hold `tx_valid` high for 0x00 then 0xFF -> the second start bit immediately follows the first stop bit with no gap. `tx_ready` pulses high for exactly one cycle between the two frames.
- Drive `rx` with a 0x3C frame -> one `rx_valid` pulse with `rx_data`=0x3C and both error flags 0.
- Drive `rx` low for 6 cycles, then high -> no `rx_valid` and FSM back in IDLE. A valid 0x81 frame sent next is received correctly.
- Drive `rx` with a frame whose stop bit is 0, followed by 40 cycles of low -> `rx_valid` with `rx_frame_err`=1. No second frame is reported until the line goes high and a new start arrives.
- With `UART_CORE_PARITY_EN` and even parity: 0x07 is transmitted with parity bit 1. An RX frame of 0x07 with parity bit 0 gives `rx_parity_err`=1. Assert reset mid-TX -> `tx`=1 and `tx_ready`=1 within the same cycle.
